// File: rtl/pad_input_reader.sv
// ---------------------------------------------------------------------------
// pad_input_reader
//
// Serial game-pad front end for a NES/SNES-style shift-register controller.
// It generates the latch and shift-clock strobes, shifts the button bits in,
// holds the last completed scan and exposes it on the CPU's memory data path
// at MMIO_ADDR with the same 1-cycle read latency as block RAM.
//
// Optional build macro:
//   PAD_INPUT_DEBOUNCE_EN - when defined, `buttons` only updates (and
//                           `scan_done` only pulses) when two consecutive
//                           completed scans are identical.
//
// Parameters:
//   CLK_DIV    system clocks per strobe tick (>= 2)
//   POLL_TICKS ticks spent idle before an automatic scan (>= 1)
//   NUM_BITS   button bits per scan, 1..16 (8 = NES, 16 = SNES)
//   MMIO_ADDR  CPU address that returns the button word
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active low
//   pad_data   serial data from the pad, active low (0 = pressed)
//   pad_latch  parallel-load strobe to the pad, active high
//   pad_clk    shift clock to the pad, idles high
//   poll       one-cycle request to start a scan while idle
//   addr       CPU address bus
//   rd_data    registered read data: buttons on a hit, else 0
//   hit        registered address match for the previous cycle's addr
//   buttons    last completed scan, bit i = i-th bit shifted out, 1 = pressed
//   scan_done  one-cycle pulse in the cycle before `buttons` updates
// ---------------------------------------------------------------------------
module pad_input_reader #(
   parameter int          CLK_DIV    = 300,
   parameter int          POLL_TICKS = 512,
   parameter int          NUM_BITS   = 16,
   parameter logic [15:0] MMIO_ADDR  = 16'hFFF0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pad_data,
   output logic        pad_latch,
   output logic        pad_clk,
   input  logic        poll,
   input  logic [15:0] addr,
   output logic [15:0] rd_data,
   output logic        hit,
   output logic [15:0] buttons,
   output logic        scan_done
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int IDLE_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam int IDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(POLL_TICKS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_LOW    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [IDLE_W-1:0] idle_cnt;
   logic              latch_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [15:0]       shreg;
   logic              commit;
   logic              hit_now;

`ifdef PAD_INPUT_DEBOUNCE_EN
   logic [15:0]       prev_raw;
`endif

   assign tick    = (div_cnt == DIV_LAST);
   assign hit_now = (addr == MMIO_ADDR);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; a poll and an idle timeout in the same cycle both
   // simply select LATCH, so the scan starts once.
   always_comb begin
      next_state = state;
      commit     = 1'b0;
      scan_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (poll || (tick && (idle_cnt == IDLE_LAST))) begin
               next_state = ST_LATCH;
            end
         end
         ST_LATCH: begin
            // Second tick in LATCH ends the parallel-load strobe.
            if (tick && latch_cnt) begin
               next_state = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (tick) begin
               next_state = (bit_idx == IDX_LAST) ? ST_DONE : ST_LOW;
            end
         end
         ST_LOW: begin
            if (tick) begin
               next_state = ST_SAMPLE;
            end
         end
         ST_DONE: begin
`ifdef PAD_INPUT_DEBOUNCE_EN
            commit = (shreg == prev_raw);
`else
            commit = 1'b1;
`endif
            scan_done  = commit;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Tick divider. It restarts from zero at LATCH entry so every scan has
   // the same phase, and is held at zero through DONE so each idle period
   // also starts on a fresh tick boundary.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if ((state == ST_IDLE) && (next_state == ST_LATCH)) begin
         div_cnt <= '0;
      end else if ((state == ST_DONE) || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Idle timer, latch tick count and bit index
   always_ff @(posedge clk) begin
      if (!reset) begin
         idle_cnt  <= '0;
         latch_cnt <= 1'b0;
         bit_idx   <= '0;
      end else begin
         if ((state == ST_IDLE) && (next_state == ST_IDLE)) begin
            if (tick) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end

         latch_cnt <= (state == ST_LATCH) ? (latch_cnt | tick) : 1'b0;

         if (state == ST_LATCH) begin
            bit_idx <= '0;
         end else if ((state == ST_LOW) && tick) begin
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   // Shift register and committed button word. Bits at or above NUM_BITS
   // are never written, so they stay zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg   <= '0;
         buttons <= '0;
      end else begin
         if ((state == ST_SAMPLE) && tick) begin
            shreg[4'(bit_idx)] <= ~pad_data;
         end else if (state == ST_DONE) begin
            shreg <= '0;
         end
         if (commit) begin
            buttons <= shreg;
         end
      end
   end

`ifdef PAD_INPUT_DEBOUNCE_EN
   // Previous raw scan, refreshed by every completed scan.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_raw <= '0;
      end else if (state == ST_DONE) begin
         prev_raw <= shreg;
      end
   end
`endif

   // Pad strobes are registered from the next state so the pad pins are
   // glitch-free yet still track the state exactly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pad_latch <= 1'b0;
         pad_clk   <= 1'b1;
      end else begin
         pad_latch <= (next_state == ST_LATCH);
         pad_clk   <= (next_state != ST_LOW);
      end
   end

   // Read port: buttons is sampled before any same-cycle DONE update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit     <= 1'b0;
         rd_data <= '0;
      end else begin
         hit     <= hit_now;
         rd_data <= hit_now ? buttons : '0;
      end
   end

endmodule
